ccff_chain_loader: RTL

Bitstream loader that sits directly upstream of the routing and connection-block configuration chain. It accepts configuration words over a valid/ready handshake and serializes them LSB-first onto `ccff_head`. It also produces a per-cycle shift enable that gates the chain's `prog_clk`, so the chain advances only when a valid bit is present. Optionally, it captures the bits leaving the chain on `ccff_tail` and returns them as readback words.

---
 rtl/ccff_chain_loader.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/ccff_chain_loader.sv
// Serializes configuration words LSB-first onto the ccff chain with a per-bit shift enable.
// Define CCFF_READBACK_EN to capture ccff_tail into readback words.
//
//   state  | meaning
//   IDLE   | waiting for start; buffers inert
//   RUN    | accepting words and shifting until CHAIN_LEN bits are out
//   FIN    | one-cycle done pulse, then back to IDLE
module ccff_chain_loader #(
  parameter int WORD_W    = 8,
  parameter int CHAIN_LEN = 4,
  parameter int CNT_W     = 16
) (
  input  logic              prog_clk,
  input  logic              prog_reset,
  input  logic              start,
  input  logic [WORD_W-1:0] word_in,
  input  logic              word_valid,
  output logic              word_ready,
  output logic              ccff_head,
  output logic              ccff_shift_en,
  input  logic              ccff_tail,
  output logic              busy,
  output logic              done,
  output logic [WORD_W-1:0] rb_data,
  output logic              rb_valid
);

  localparam int NWORDS = (CHAIN_LEN + WORD_W - 1) / WORD_W;
  localparam int SB_W   = $clog2(WORD_W + 1);

  localparam logic [CNT_W-1:0] CHAIN_LEN_C = CNT_W'(CHAIN_LEN);
  localparam logic [CNT_W-1:0] NWORDS_C    = CNT_W'(NWORDS);
  localparam logic [SB_W-1:0]  WORD_W_C    = SB_W'(WORD_W);
  localparam logic [SB_W-1:0]  SBITS_ONE   = SB_W'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FIN
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   bit_cnt;
  logic [CNT_W-1:0]   words_acc;
  logic [WORD_W-1:0]  sreg;
  logic [SB_W-1:0]    sbits;
  logic [WORD_W-1:0]  hold;
  logic               hold_full;

  logic shift_now;
  logic sreg_free;
  logic hs;

  assign word_ready = (state == S_RUN) && !hold_full && (words_acc < NWORDS_C);
  assign hs         = word_valid && word_ready;
  assign shift_now  = (state == S_RUN) && (sbits != '0) && (bit_cnt < CHAIN_LEN_C);
  // sreg can take a new word when it is empty or its last bit leaves this cycle
  assign sreg_free  = (sbits == '0) || (shift_now && (sbits == SBITS_ONE));

  always_ff @(posedge prog_clk or posedge prog_reset) begin
    if (prog_reset) begin
      state         <= S_IDLE;
      busy          <= 1'b0;
      done          <= 1'b0;
      bit_cnt       <= '0;
      words_acc     <= '0;
      sreg          <= '0;
      sbits         <= '0;
      hold          <= '0;
      hold_full     <= 1'b0;
      ccff_head     <= 1'b0;
      ccff_shift_en <= 1'b0;
    end else begin
      done          <= 1'b0;
      ccff_shift_en <= shift_now;
      if (shift_now) begin
        ccff_head <= sreg[0];
      end
      case (state)
        S_IDLE: begin
          if (start) begin
            state     <= S_RUN;
            busy      <= 1'b1;
            bit_cnt   <= '0;
            words_acc <= '0;
            sbits     <= '0;
            hold_full <= 1'b0;
          end
        end
        S_RUN: begin
          if (shift_now) begin
            bit_cnt <= bit_cnt + 1'b1;
          end
          if (hs) begin
            words_acc <= words_acc + 1'b1;
          end
          if (sreg_free) begin
            if (hold_full) begin
              sreg      <= hold;
              sbits     <= WORD_W_C;
              hold_full <= 1'b0;
            end else if (hs) begin
              sreg  <= word_in;
              sbits <= WORD_W_C;
            end else if (shift_now) begin
              sreg  <= sreg >> 1;
              sbits <= sbits - 1'b1;
            end
          end else begin
            if (shift_now) begin
              sreg  <= sreg >> 1;
              sbits <= sbits - 1'b1;
            end
            if (hs) begin
              hold      <= word_in;
              hold_full <= 1'b1;
            end
          end
          if (bit_cnt == CHAIN_LEN_C) begin
            state <= S_FIN;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        S_FIN: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

`ifdef CCFF_READBACK_EN
  localparam logic [SB_W-1:0]  RB_LAST = SB_W'(WORD_W - 1);
  localparam logic [CNT_W-1:0] CL_LAST = CNT_W'(CHAIN_LEN - 1);

  logic [WORD_W-1:0] rb_pack;
  logic [WORD_W-1:0] rb_next;
  logic [SB_W-1:0]   rb_cnt;
  logic [CNT_W-1:0]  rb_total;

  assign rb_next = rb_pack | (WORD_W'(ccff_tail) << rb_cnt);

  // the edge ending a shift-enable cycle is the one where the chain ejects ccff_tail
  always_ff @(posedge prog_clk or posedge prog_reset) begin
    if (prog_reset) begin
      rb_pack  <= '0;
      rb_cnt   <= '0;
      rb_total <= '0;
      rb_data  <= '0;
      rb_valid <= 1'b0;
    end else begin
      rb_valid <= 1'b0;
      if ((state == S_IDLE) && start) begin
        rb_pack  <= '0;
        rb_cnt   <= '0;
        rb_total <= '0;
      end else if (ccff_shift_en) begin
        rb_total <= rb_total + 1'b1;
        if ((rb_cnt == RB_LAST) || (rb_total == CL_LAST)) begin
          rb_data  <= rb_next;
          rb_valid <= 1'b1;
          rb_pack  <= '0;
          rb_cnt   <= '0;
        end else begin
          rb_pack <= rb_next;
          rb_cnt  <= rb_cnt + 1'b1;
        end
      end
    end
  end
`else
  logic unused_tail;
  assign unused_tail = ccff_tail;
  assign rb_data     = '0;
  assign rb_valid    = 1'b0;
`endif

endmodule
